id_imm_stage: RTL and testbench

ID-side immediate generation plus ID/EX pipeline register for the pipelined LEGv8 core.
- Extracts the immediate field of the decoded instruction and zero- or sign-extends it to DATA_WIDTH.
- Applies the branch shift or the MOV halfword shift.
- Registers the result with the instruction, PC and valid bit, under hazard-unit stall/flush control, for consumption by EX (ALU B-mux, branch adder).

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/imm_gen.sv | 83 ++++++++
 rtl/sign_extender.sv | 15 +
 rtl/zero_extender.sv | 15 +
 rtl/id_imm_stage.sv | 76 +++++++
 tb/tb_id_imm_stage.sv | 165 ++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and field constants for the LEGv8 ID stage
// Purpose: immediate-kind encoding, instruction field positions and the
//          branch / MOV shift constants used by imm_gen and id_imm_stage.
// Ports:   none (package).
package cpu_pkg;

   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_ALU   = 3'd1,
      IMM_DT    = 3'd2,
      IMM_BR    = 3'd3,
      IMM_CB    = 3'd4,
      IMM_MOV   = 3'd5,
      IMM_SHAMT = 3'd6
   } imm_sel_t;

   // I-format ALU immediate
   localparam int ALU_IMM_MSB   = 21;
   localparam int ALU_IMM_LSB   = 10;
   // D-format address offset
   localparam int DT_IMM_MSB    = 20;
   localparam int DT_IMM_LSB    = 12;
   // B-format branch offset
   localparam int BR_IMM_MSB    = 25;
   localparam int BR_IMM_LSB    = 0;
   // CB-format branch offset
   localparam int CB_IMM_MSB    = 23;
   localparam int CB_IMM_LSB    = 5;
   // IM-format MOV immediate and halfword select
   localparam int MOV_IMM_MSB   = 20;
   localparam int MOV_IMM_LSB   = 5;
   localparam int MOV_HW_MSB    = 22;
   localparam int MOV_HW_LSB    = 21;
   // R-format shift amount
   localparam int SHAMT_MSB     = 15;
   localparam int SHAMT_LSB     = 10;

   localparam int BR_CB_SHIFT   = 2;
   localparam int MOV_HW_SHIFT  = 16;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - LEGv8 immediate extraction, extension and shift
// Purpose: produce the DATA_WIDTH immediate for the instruction in ID.
// Ports:   instr    [INSTR_WIDTH-1:0] instruction from IF/ID
//          imm_sel  [2:0]             immediate kind (imm_sel_t)
//          imm_next [DATA_WIDTH-1:0]  extended and shifted immediate
module imm_gen
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [2:0]             imm_sel,
   output logic [DATA_WIDTH-1:0]  imm_next
);

   localparam int ALU_W   = ALU_IMM_MSB - ALU_IMM_LSB + 1;
   localparam int DT_W    = DT_IMM_MSB  - DT_IMM_LSB  + 1;
   localparam int BR_W    = BR_IMM_MSB  - BR_IMM_LSB  + 1;
   localparam int CB_W    = CB_IMM_MSB  - CB_IMM_LSB  + 1;
   localparam int MOV_W   = MOV_IMM_MSB - MOV_IMM_LSB + 1;
   localparam int SHAMT_W = SHAMT_MSB   - SHAMT_LSB   + 1;

   logic [DATA_WIDTH-1:0] alu_ext;
   logic [DATA_WIDTH-1:0] dt_ext;
   logic [DATA_WIDTH-1:0] br_ext;
   logic [DATA_WIDTH-1:0] cb_ext;
   logic [DATA_WIDTH-1:0] mov_ext;
   logic [DATA_WIDTH-1:0] shamt_ext;
   logic [6:0]            mov_shift;

   // Opcode bits above the widest field never feed the immediate.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[INSTR_WIDTH-1:BR_IMM_MSB+1];

   zero_extender #(.IN_W(ALU_W), .OUT_W(DATA_WIDTH)) u_alu_ext (
      .din  (instr[ALU_IMM_MSB:ALU_IMM_LSB]),
      .dout (alu_ext)
   );

   sign_extender #(.IN_W(DT_W), .OUT_W(DATA_WIDTH)) u_dt_ext (
      .din  (instr[DT_IMM_MSB:DT_IMM_LSB]),
      .dout (dt_ext)
   );

   sign_extender #(.IN_W(BR_W), .OUT_W(DATA_WIDTH)) u_br_ext (
      .din  (instr[BR_IMM_MSB:BR_IMM_LSB]),
      .dout (br_ext)
   );

   sign_extender #(.IN_W(CB_W), .OUT_W(DATA_WIDTH)) u_cb_ext (
      .din  (instr[CB_IMM_MSB:CB_IMM_LSB]),
      .dout (cb_ext)
   );

   zero_extender #(.IN_W(MOV_W), .OUT_W(DATA_WIDTH)) u_mov_ext (
      .din  (instr[MOV_IMM_MSB:MOV_IMM_LSB]),
      .dout (mov_ext)
   );

   zero_extender #(.IN_W(SHAMT_W), .OUT_W(DATA_WIDTH)) u_shamt_ext (
      .din  (instr[SHAMT_MSB:SHAMT_LSB]),
      .dout (shamt_ext)
   );

   // hw * 16 is just hw placed above four zero bits; every hw value is legal.
   assign mov_shift = 7'(instr[MOV_HW_MSB:MOV_HW_LSB]) * 7'(MOV_HW_SHIFT);

   // Left shifts keep DATA_WIDTH; bits moved past the MSB are dropped.
   always_comb begin
      imm_next = '0;
      case (imm_sel)
         IMM_ALU:   imm_next = alu_ext;
         IMM_DT:    imm_next = dt_ext;
         IMM_BR:    imm_next = br_ext << BR_CB_SHIFT;
         IMM_CB:    imm_next = cb_ext << BR_CB_SHIFT;
         IMM_MOV:   imm_next = mov_ext << mov_shift;
         IMM_SHAMT: imm_next = shamt_ext;
         default:   imm_next = '0;
      endcase
   end

endmodule

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - sign-extend an IN_W-bit field to OUT_W bits
// Purpose: combinational two's-complement sign extension.
// Ports:   din  [IN_W-1:0]  field to extend (MSB is the sign)
//          dout [OUT_W-1:0] sign-extended result
module sign_extender #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 64
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/zero_extender.sv
// rtl/zero_extender.sv - zero-extend an IN_W-bit field to OUT_W bits
// Purpose: combinational zero extension.
// Ports:   din  [IN_W-1:0]  field to extend
//          dout [OUT_W-1:0] zero-extended result
module zero_extender #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 64
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   assign dout = {{(OUT_W-IN_W){1'b0}}, din};

endmodule

// File: rtl/id_imm_stage.sv
// rtl/id_imm_stage.sv - ID immediate generation and ID/EX pipeline register
// Purpose: extend the ID instruction's immediate and register it with the
//          instruction, PC and valid bit under stall/flush control.
// Ports:   clk, reset (async, active-high)
//          instr_in, pc_in, valid_in, imm_sel  from IF/ID and control
//          stall, flush                        from the hazard unit
//          imm_q, instr_q, pc_q, valid_q       ID/EX register to EX
module id_imm_stage
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   input  logic [DATA_WIDTH-1:0]  pc_in,
   input  logic                   valid_in,
   input  logic [2:0]             imm_sel,
   input  logic                   stall,
   input  logic                   flush,
   output logic [DATA_WIDTH-1:0]  imm_q,
   output logic [INSTR_WIDTH-1:0] instr_q,
   output logic [DATA_WIDTH-1:0]  pc_q,
   output logic                   valid_q
);

   logic [DATA_WIDTH-1:0]  imm_next;
   logic [DATA_WIDTH-1:0]  imm_d;
   logic [INSTR_WIDTH-1:0] instr_d;
   logic [DATA_WIDTH-1:0]  pc_d;
   logic                   valid_d;

   imm_gen #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_imm_gen (
      .instr    (instr_in),
      .imm_sel  (imm_sel),
      .imm_next (imm_next)
   );

   // Flush beats stall: a squashed instruction must not survive a held stage.
   always_comb begin
      imm_d   = imm_next;
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = valid_in;
      if (flush) begin
         imm_d   = '0;
         instr_d = '0;
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         imm_d   = imm_q;
         instr_d = instr_q;
         pc_d    = pc_q;
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imm_q   <= '0;
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         imm_q   <= imm_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_id_imm_stage.sv
// tb/tb_id_imm_stage.sv - directed self-checking bench for id_imm_stage
module tb_id_imm_stage;

   logic        clk;
   logic        reset;
   logic [31:0] instr_in;
   logic [63:0] pc_in;
   logic        valid_in;
   logic [2:0]  imm_sel;
   logic        stall;
   logic        flush;
   logic [63:0] imm_q;
   logic [31:0] instr_q;
   logic [63:0] pc_q;
   logic        valid_q;

   int checks;
   int errors;

   id_imm_stage #(.DATA_WIDTH(64), .INSTR_WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .instr_in (instr_in),
      .pc_in    (pc_in),
      .valid_in (valid_in),
      .imm_sel  (imm_sel),
      .stall    (stall),
      .flush    (flush),
      .imm_q    (imm_q),
      .instr_q  (instr_q),
      .pc_q     (pc_q),
      .valid_q  (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all(input string tag, input logic [63:0] e_imm, input logic [31:0] e_instr,
                          input logic [63:0] e_pc, input logic e_valid);
      chk({tag, ".imm"},   imm_q,          e_imm);
      chk({tag, ".instr"}, {32'h0, instr_q}, {32'h0, e_instr});
      chk({tag, ".pc"},    pc_q,           e_pc);
      chk({tag, ".valid"}, {63'h0, valid_q}, {63'h0, e_valid});
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] sel, input logic [31:0] ins, input logic [63:0] pc, input logic v);
      imm_sel  = sel;
      instr_in = ins;
      pc_in    = pc;
      valid_in = v;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      load(3'd1, 32'hFFFF_FFFF, 64'h40, 1'b1);
      #7;
      chk_all("reset", 64'h0, 32'h0, 64'h0, 1'b0);
      reset = 1'b0;

      // ALU immediate, then asynchronous reset between edges
      cycle();
      chk_all("alu", 64'h0000_0000_0000_0FFF, 32'hFFFF_FFFF, 64'h40, 1'b1);
      #3 reset = 1'b1;
      #1;
      chk_all("async_reset", 64'h0, 32'h0, 64'h0, 1'b0);
      #1 reset = 1'b0;

      // DT offset: negative then positive with bit 21 set outside the field
      load(3'd2, 32'h001F_F000, 64'h44, 1'b1);
      cycle();
      chk("dt_neg", imm_q, 64'hFFFF_FFFF_FFFF_FFFF);
      load(3'd2, 32'h002F_F000, 64'h48, 1'b1);
      cycle();
      chk("dt_pos", imm_q, 64'h0000_0000_0000_00FF);

      // Branch offsets
      load(3'd3, 32'h1400_0001, 64'h4C, 1'b1);
      cycle();
      chk("br", imm_q, 64'h4);
      load(3'd4, 32'hB4FF_FFE0, 64'h50, 1'b1);
      cycle();
      chk("cb", imm_q, 64'hFFFF_FFFF_FFFF_FFFC);

      // MOV halfword shifts
      load(3'd5, 32'hD2D7_DDE0, 64'h54, 1'b1);
      cycle();
      chk("mov_hw2", imm_q, 64'h0000_BEEF_0000_0000);
      load(3'd5, 32'hD2F7_DDE0, 64'h58, 1'b1);
      cycle();
      chk("mov_hw3", imm_q, 64'hBEEF_0000_0000_0000);
      load(3'd5, 32'hD297_DDE0, 64'h5C, 1'b1);
      cycle();
      chk("mov_hw0", imm_q, 64'h0000_0000_0000_BEEF);

      // SHAMT, NONE and an unused code
      load(3'd6, 32'hFFFF_FFFF, 64'h60, 1'b1);
      cycle();
      chk("shamt", imm_q, 64'h3F);
      load(3'd0, 32'hFFFF_FFFF, 64'h64, 1'b1);
      cycle();
      chk("none", imm_q, 64'h0);
      load(3'd7, 32'hFFFF_FFFF, 64'h68, 1'b1);
      cycle();
      chk("unused_code", imm_q, 64'h0);

      // Stall holds for three edges while inputs change
      load(3'd1, 32'h0000_0400, 64'h100, 1'b1);
      cycle();
      chk_all("pre_stall", 64'h1, 32'h0000_0400, 64'h100, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         load(3'd2, 32'h001F_F000 + i, 64'h180 + i, 1'b0);
         cycle();
         chk_all($sformatf("stall%0d", i), 64'h1, 32'h0000_0400, 64'h100, 1'b1);
      end
      stall = 1'b0;
      load(3'd1, 32'h0000_0800, 64'h200, 1'b1);
      cycle();
      chk_all("stall_release", 64'h2, 32'h0000_0800, 64'h200, 1'b1);

      // Flush wins over stall
      stall = 1'b1;
      flush = 1'b1;
      cycle();
      chk_all("flush_stall", 64'h0, 32'h0, 64'h0, 1'b0);
      stall = 1'b0;
      flush = 1'b0;

      // Bubble load still captures the other fields
      load(3'd1, 32'h0000_0C00, 64'h300, 1'b0);
      cycle();
      chk_all("bubble", 64'h3, 32'h0000_0C00, 64'h300, 1'b0);

      // Flush alone from a valid entry
      load(3'd1, 32'h0000_1000, 64'h400, 1'b1);
      cycle();
      chk("valid_again", {63'h0, valid_q}, 64'h1);
      flush = 1'b1;
      cycle();
      chk_all("flush", 64'h0, 32'h0, 64'h0, 1'b0);
      flush = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
